// File: rtl/mem_stage.sv
// Memory-access stage: turns execute results into data-memory requests
// over a req/ack handshake and produces single-cycle writeback records.
module mem_stage #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] ALU_results,
    input  logic [2:0]        dest_reg,
    input  logic [DATA_W-1:0] store_data,
    input  logic              is_load,
    input  logic              is_store,
    input  logic              wb_en,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic [2:0]        wb_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              mem_err
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned REG_W = 3;

    typedef enum logic {IDLE, ACCESS} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [DATA_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               wb_valid_q, wb_valid_d;
    logic [REG_W-1:0]   wb_reg_q, wb_reg_d;
    logic [DATA_W-1:0]  wb_data_q, wb_data_d;
    logic               err_q, err_d;
    logic               pend_wb_q, pend_wb_d;
    logic [REG_W-1:0]   pend_reg_q, pend_reg_d;
    logic               kill_q, kill_d;

    assign in_ready  = (state_q == IDLE);
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_reg    = wb_reg_q;
    assign wb_data   = wb_data_q;
    assign mem_err   = err_q;

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wb_valid_d = 1'b0;
        wb_reg_d   = wb_reg_q;
        wb_data_d  = wb_data_q;
        err_d      = 1'b0;
        pend_wb_d  = pend_wb_q;
        pend_reg_d = pend_reg_q;
        kill_d     = kill_q;

        case (state_q)
            IDLE: begin
                if (in_valid && !flush) begin
                    if (is_load && is_store) begin
                        err_d = 1'b1;
                    end else if (is_load || is_store) begin
                        state_d    = ACCESS;
                        cnt_d      = '0;
                        req_d      = 1'b1;
                        we_d       = is_store;
                        addr_d     = ALU_results;
                        wdata_d    = is_store ? store_data : '0;
                        pend_wb_d  = wb_en;
                        pend_reg_d = dest_reg;
                        kill_d     = 1'b0;
                    end else begin
                        wb_valid_d = wb_en;
                        wb_reg_d   = dest_reg;
                        wb_data_d  = ALU_results;
                    end
                end
            end
            ACCESS: begin
                if (flush) kill_d = 1'b1;
                // An ack on the final allowed cycle still counts as completion
                if (mem_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    if (!we_q && pend_wb_q && !kill_q && !flush) begin
                        wb_valid_d = 1'b1;
                        wb_reg_d   = pend_reg_q;
                        wb_data_d  = mem_rdata;
                    end
                end else if (cnt_q + CNT_W'(1) == CNT_W'(TIMEOUT)) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_reg_q   <= '0;
            wb_data_q  <= '0;
            err_q      <= 1'b0;
            pend_wb_q  <= 1'b0;
            pend_reg_q <= '0;
            kill_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wb_valid_q <= wb_valid_d;
            wb_reg_q   <= wb_reg_d;
            wb_data_q  <= wb_data_d;
            err_q      <= err_d;
            pend_wb_q  <= pend_wb_d;
            pend_reg_q <= pend_reg_d;
            kill_q     <= kill_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU writeback, load/store handshakes,
// timeout, flush, illegal op and asynchronous reset mid-access.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] ALU_results;
    logic [2:0]  dest_reg;
    logic [15:0] store_data;
    logic        is_load;
    logic        is_store;
    logic        wb_en;
    logic        flush;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        wb_valid;
    logic [2:0]  wb_reg;
    logic [15:0] wb_data;
    logic        mem_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage #(.DATA_W(16), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ALU_results(ALU_results), .dest_reg(dest_reg), .store_data(store_data),
        .is_load(is_load), .is_store(is_store), .wb_en(wb_en), .flush(flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
        .wb_reg(wb_reg), .wb_data(wb_data), .mem_err(mem_err)
    );

    // Advance one clock; outputs are sampled 1ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = 0; ALU_results = '0; dest_reg = '0; store_data = '0;
        is_load = 0; is_store = 0; wb_en = 0; flush = 0; mem_ack = 0; mem_rdata = '0;
    endtask

    task automatic issue(input logic ld, input logic st, input logic [15:0] alu,
                         input logic [2:0] rd, input logic [15:0] sd, input logic we);
        in_valid = 1; is_load = ld; is_store = st; ALU_results = alu;
        dest_reg = rd; store_data = sd; wb_en = we;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        #12;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%0h exp=0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%0h exp=0", mem_we); end
        checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0000", mem_addr); end
        checks++; if (mem_wdata !== 16'h0) begin errors++; $display("FAIL reset_mem_wdata got=%h exp=0000", mem_wdata); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got=%0h exp=0", wb_valid); end
        checks++; if (wb_reg !== 3'd0) begin errors++; $display("FAIL reset_wb_reg got=%0d exp=0", wb_reg); end
        checks++; if (wb_data !== 16'h0) begin errors++; $display("FAIL reset_wb_data got=%h exp=0000", wb_data); end
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL reset_mem_err got=%0h exp=0", mem_err); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
        @(negedge clk);
        rst_n = 1;
        step();
    endtask

    task automatic test_alu();
        logic [15:0] v;
        issue(0, 0, 16'h1234, 3'd3, 16'h0, 1);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL alu_in_ready got=%0h exp=1", in_ready); end
        step();
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL alu_wb_valid got=%0h exp=1", wb_valid); end
        checks++; if (wb_reg !== 3'd3) begin errors++; $display("FAIL alu_wb_reg got=%0d exp=3", wb_reg); end
        checks++; if (wb_data !== 16'h1234) begin errors++; $display("FAIL alu_wb_data got=%h exp=1234", wb_data); end
        for (int i = 1; i <= 3; i++) begin
            v = 16'h1111 * 16'(i);
            issue(0, 0, v, 3'(i + 3), 16'h0, 1);
            step();
            checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL b2b_wb_valid[%0d] got=%0h exp=1", i, wb_valid); end
            checks++; if (wb_reg !== 3'(i + 3)) begin errors++; $display("FAIL b2b_wb_reg[%0d] got=%0d exp=%0d", i, wb_reg, i + 3); end
            checks++; if (wb_data !== v) begin errors++; $display("FAIL b2b_wb_data[%0d] got=%h exp=%h", i, wb_data, v); end
        end
        issue(0, 0, 16'h5555, 3'd2, 16'h0, 0);
        step();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL alu_nowb_wb_valid got=%0h exp=0", wb_valid); end
        clear_inputs();
        step();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL alu_idle_wb_valid got=%0h exp=0", wb_valid); end
    endtask

    task automatic test_load();
        issue(1, 0, 16'h0040, 3'd5, 16'h0, 1);
        step();
        // An ALU op held on in_valid during ACCESS must be ignored
        issue(0, 0, 16'h9999, 3'd1, 16'h0, 1);
        for (int c = 0; c < 4; c++) begin
            checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL load_req[%0d] got=%0h exp=1", c, mem_req); end
            checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL load_we[%0d] got=%0h exp=0", c, mem_we); end
            checks++; if (mem_addr !== 16'h0040) begin errors++; $display("FAIL load_addr[%0d] got=%h exp=0040", c, mem_addr); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL load_in_ready[%0d] got=%0h exp=0", c, in_ready); end
            checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL load_early_wb[%0d] got=%0h exp=0", c, wb_valid); end
            if (c == 3) begin
                clear_inputs();
                mem_ack = 1; mem_rdata = 16'hBEEF;
            end
            step();
        end
        mem_ack = 0; mem_rdata = 16'h0;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL load_req_drop got=%0h exp=0", mem_req); end
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL load_wb_valid got=%0h exp=1", wb_valid); end
        checks++; if (wb_reg !== 3'd5) begin errors++; $display("FAIL load_wb_reg got=%0d exp=5", wb_reg); end
        checks++; if (wb_data !== 16'hBEEF) begin errors++; $display("FAIL load_wb_data got=%h exp=beef", wb_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL load_in_ready_back got=%0h exp=1", in_ready); end
        step();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL load_wb_pulse got=%0h exp=0", wb_valid); end
    endtask

    task automatic test_store();
        issue(0, 1, 16'h0100, 3'd6, 16'hA5A5, 1);
        step();
        clear_inputs();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL store_req got=%0h exp=1", mem_req); end
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL store_we got=%0h exp=1", mem_we); end
        checks++; if (mem_addr !== 16'h0100) begin errors++; $display("FAIL store_addr got=%h exp=0100", mem_addr); end
        checks++; if (mem_wdata !== 16'hA5A5) begin errors++; $display("FAIL store_wdata got=%h exp=a5a5", mem_wdata); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL store_in_ready got=%0h exp=0", in_ready); end
        mem_ack = 1;
        step();
        mem_ack = 0;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL store_req_drop got=%0h exp=0", mem_req); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL store_wb got=%0h exp=0", wb_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL store_in_ready_back got=%0h exp=1", in_ready); end
    endtask

    task automatic test_timeout();
        int n;
        issue(1, 0, 16'h0200, 3'd2, 16'h0, 1);
        step();
        clear_inputs();
        n = 0;
        while (mem_req === 1'b1 && n < 40) begin
            if (mem_err !== 1'b0) begin checks++; errors++; $display("FAIL to_err_early[%0d] got=%0h exp=0", n, mem_err); end
            n++;
            step();
        end
        checks++; if (n != 15) begin errors++; $display("FAIL to_req_cycles got=%0d exp=15", n); end
        checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL to_err got=%0h exp=1", mem_err); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL to_wb got=%0h exp=0", wb_valid); end
        step();
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL to_err_pulse got=%0h exp=0", mem_err); end
        // Ack on the 15th request cycle completes normally
        issue(1, 0, 16'h0202, 3'd7, 16'h0, 1);
        step();
        clear_inputs();
        for (int c = 1; c <= 15; c++) begin
            checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL to15_req[%0d] got=%0h exp=1", c, mem_req); end
            if (c == 15) begin mem_ack = 1; mem_rdata = 16'h7777; end
            step();
        end
        mem_ack = 0;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL to15_req_drop got=%0h exp=0", mem_req); end
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL to15_err got=%0h exp=0", mem_err); end
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL to15_wb_valid got=%0h exp=1", wb_valid); end
        checks++; if (wb_data !== 16'h7777) begin errors++; $display("FAIL to15_wb_data got=%h exp=7777", wb_data); end
        step();
    endtask

    task automatic test_flush();
        issue(1, 0, 16'h0300, 3'd4, 16'h0, 1);
        step();
        clear_inputs();
        flush = 1;
        step();
        flush = 0;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL fl_acc_req got=%0h exp=1", mem_req); end
        step();
        mem_ack = 1; mem_rdata = 16'h1357;
        step();
        mem_ack = 0;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fl_acc_req_drop got=%0h exp=0", mem_req); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL fl_acc_wb got=%0h exp=0", wb_valid); end
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL fl_acc_err got=%0h exp=0", mem_err); end
        issue(1, 0, 16'h0400, 3'd1, 16'h0, 1);
        flush = 1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fl_idle_in_ready got=%0h exp=1", in_ready); end
        step();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fl_idle_req got=%0h exp=0", mem_req); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fl_idle_in_ready2 got=%0h exp=1", in_ready); end
        issue(0, 0, 16'h0ABC, 3'd1, 16'h0, 1);
        step();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL fl_idle_wb got=%0h exp=0", wb_valid); end
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL fl_idle_err got=%0h exp=0", mem_err); end
        clear_inputs();
        step();
    endtask

    task automatic test_illegal();
        issue(1, 1, 16'h0500, 3'd3, 16'h1111, 1);
        step();
        clear_inputs();
        checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL ill_err got=%0h exp=1", mem_err); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL ill_req got=%0h exp=0", mem_req); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL ill_wb got=%0h exp=0", wb_valid); end
        step();
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL ill_err_pulse got=%0h exp=0", mem_err); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL ill_req2 got=%0h exp=0", mem_req); end
    endtask

    task automatic test_reset_mid();
        issue(0, 1, 16'h0600, 3'd2, 16'hCAFE, 0);
        step();
        clear_inputs();
        step();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rm_req_before got=%0h exp=1", mem_req); end
        #2 rst_n = 0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rm_req got=%0h exp=0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rm_we got=%0h exp=0", mem_we); end
        checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL rm_addr got=%h exp=0000", mem_addr); end
        checks++; if (mem_wdata !== 16'h0) begin errors++; $display("FAIL rm_wdata got=%h exp=0000", mem_wdata); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready got=%0h exp=1", in_ready); end
        mem_ack = 1; mem_rdata = 16'hDEAD;
        step();
        rst_n = 1;
        step();
        mem_ack = 0;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rm_late_ack_req got=%0h exp=0", mem_req); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rm_late_ack_wb got=%0h exp=0", wb_valid); end
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL rm_late_ack_err got=%0h exp=0", mem_err); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_timeout();
        test_flush();
        test_illegal();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
